// File: rtl/cd_bcd_scan_mux.sv
// Four-digit multiplexed BCD display scanner.
// A prescaler paces the digit slots. New digit data is double-buffered and
// swapped in only at a frame boundary so a frame never mixes two words.
// Leading zeros can be blanked, and digits holding codes above 9 are blanked
// and reported through a sticky error flag.
module cd_bcd_scan_mux #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned   CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT3 = 2'd3;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          boundary;

    logic [15:0]   act_dig;
    logic [3:0]    act_dp;
    logic [15:0]   pend_dig;
    logic [3:0]    pend_dp;
    logic          pend_valid;
    logic          pend_bad;

    logic [15:0]   show_dig;
    logic [3:0]    show_dp;
    logic [3:0]    lead_zero;
    logic [3:0]    sel_dig;
    logic          sel_dp;
    logic          sel_blank;

    // Slot timing and selection of the digit for the upcoming slot.
    always_comb begin
        tick     = (cnt == LAST);
        idx_nxt  = idx + 2'd1;
        boundary = tick && (idx == SLOT3);

        // At a boundary with a swap pending, digit 0 must already come from
        // the incoming word, so the display view looks through to pending.
        if (boundary && pend_valid) begin
            show_dig = pend_dig;
            show_dp  = pend_dp;
        end else begin
            show_dig = act_dig;
            show_dp  = act_dp;
        end

        lead_zero    = '0;
        lead_zero[3] = (show_dig[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (show_dig[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (show_dig[7:4] == 4'd0);

        sel_dig   = show_dig[{idx_nxt, 2'b00} +: 4];
        sel_dp    = show_dp[idx_nxt];
        sel_blank = (sel_dig > 4'd9) || (blank_lz && lead_zero[idx_nxt]);

        pend_bad = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pend_dig[i*4 +: 4] > 4'd9) begin
                pend_bad = 1'b1;
            end
        end
    end

    // Prescaler: free-running count that wraps at PRESCALE-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Digit index: starts at 3 so the first tick after reset is a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= SLOT3;
        end else if (tick) begin
            idx <= idx_nxt;
        end
    end

    // Pending/active double buffer and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_dig    <= '0;
            act_dp     <= '0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                act_dig <= pend_dig;
                act_dp  <= pend_dp;
                err     <= pend_bad;
            end
            // A load in the boundary cycle survives the swap and waits a frame.
            if (load) begin
                pend_dig   <= digits_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Registered display outputs, updated only on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            bcd_out    <= '0;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                if (sel_blank) begin
                    an      <= '1;
                    bcd_out <= '0;
                    dp_n    <= 1'b1;
                end else begin
                    an      <= ~(4'b0001 << idx_nxt);
                    bcd_out <= sel_dig;
                    dp_n    <= ~sel_dp;
                end
            end
        end
    end

    logic unused_slot0;
    assign unused_slot0 = (SLOT0 == 2'd0);

endmodule

// File: doc/cd_bcd_scan_mux.md
CD_BCD_SCAN_MUX -- requirements
Module: cd_bcd_scan_mux

Interface
REQ-001 Parameter PRESCALE, default 100000, meaning clocks per digit slot (legal range 2..2^20).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  strobe; captures digits_in/dp_in into the pending register.
REQ-005 digits_in  input  16  four BCD digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-006 dp_in  input  4  decimal point per digit, 1 = lit; bit i = digit i.
REQ-007 blank_lz  input  1  1 = enable leading-zero blanking.
REQ-008 bcd_out  output  4  BCD code of the selected digit, bit order D,C,B,A, feeding the 7-segment decoder.
REQ-009 an  output  4  digit enables, active-low, one-hot-zero.
REQ-010 dp_n  output  1  decimal point of the selected digit, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-012 err  output  1  sticky flag: an active digit holds a code >9.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and wraps; tick asserts for one cycle when count = PRESCALE-1.
REQ-014 2-bit digit index advances 0->1->2->3->0 on each tick, so the next slot enable is asserted the cycle after the tick.
REQ-015 All outputs are registered and update only on the cycle after a tick; between ticks they hold.
REQ-016 On a tick with new index i: an = 0 at bit i only, bcd_out = active digit i, dp_n = ~active dp i.
REQ-017 Load: pending <= {digits_in, dp_in}, pend_valid <= 1; the displayed active register is unchanged.
REQ-018 Frame boundary = tick with index advancing 3->0: if pend_valid, active <= pending, pend_valid <= 0; frame_done pulses in the same cycle as the outputs switching to digit 0.
REQ-019 Digit 0 displayed in the new frame uses the newly transferred value; no mixing of old and new data within a frame.
REQ-020 Load coincident with the boundary cycle: the transfer uses pending as it was before that cycle; the new load is held with pend_valid = 1 and transferred at the next boundary.
REQ-021 Back-to-back loads within one frame: the last load wins.
REQ-022 Leading-zero blanking (blank_lz = 1): digit k (k = 3..1) is blanked when active digits k..3 are all 0; digit 0 is never blanked.
REQ-023 Invalid code (active digit >9): that digit is blanked and err <= 1.
REQ-024 Blanked slot: an = 4'b1111 for the slot duration, bcd_out = 4'h0, dp_n = ~dp (dp still shown only if the digit is not blanked; if blanked, dp_n = 1).
REQ-025 err clears on the frame boundary that transfers a pending word containing no code >9.
REQ-026 blank_lz is sampled at each tick; a change takes effect from the next slot.

Reset
REQ-027 While rst = 1: prescaler = 0, index = 3, active = 0, pending = 0, pend_valid = 0, an = 4'b1111, bcd_out = 4'h0, dp_n = 1, frame_done = 0, err = 0.
REQ-028 After rst deassertion, the first tick (PRESCALE clocks later) is a frame boundary and selects digit 0.
REQ-029 Reset mid-frame or mid-load discards pending and active data immediately; no pulse on frame_done.

Verification (bench PRESCALE = 4)
REQ-030 Reset release with no load -> an goes 1111 then 1110 after 4 clocks, bcd_out = 0, frame_done pulses once; slots rotate 1110, 1101, 1011, 0111 every 4 clocks.
REQ-031 load digits_in = 16'h1234, dp_in = 4'b0100 mid-frame -> display unchanged until next boundary; then slot 0 shows 4, slot 1 shows 3, slot 2 shows 2 with dp_n = 0, slot 3 shows 1.
REQ-032 blank_lz = 1, load 16'h0050 -> slots 3 and 2 show an = 1111; slot 1 shows 5; slot 0 shows 0; load 16'h0000 -> only slot 0 is lit, showing 0.
REQ-033 Load 16'h12A4 -> slot 1 blanked, err = 1 after boundary; then load 16'h1234 -> err = 0 at the following boundary.
REQ-034 Load asserted exactly in the boundary cycle with 16'h9999 while pending = 16'h1111 -> frame N shows 1111, frame N+1 shows 9999.
REQ-035 rst pulsed for 1 clock mid-slot after loading 16'h8888 -> outputs return to reset values asynchronously; next frame shows 0000.
